// File: rtl/noc_pkg.sv
// Shared NoC definitions: port numbering, route mask type and the
// minimal-path route computation used by every input buffer.
package noc_pkg;

  localparam int NUM_PORTS  = 7;
  localparam int PORT_WEST  = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_EAST  = 2;
  localparam int PORT_SOUTH = 3;
  localparam int PORT_UP    = 4;
  localparam int PORT_DOWN  = 5;
  localparam int PORT_LOCAL = 6;

  // Coordinates are zero-extended to this width so one function serves any
  // COORD_WIDTH up to 16 without changing the unsigned ordering.
  localparam int MAX_COORD_WIDTH = 16;

  typedef logic [NUM_PORTS-1:0]       port_mask_t;
  typedef logic [MAX_COORD_WIDTH-1:0] coord_t;

  typedef struct packed {
    coord_t z;
    coord_t y;
    coord_t x;
  } mesh_pos_t;

  function automatic port_mask_t compute_route(input mesh_pos_t dest, input mesh_pos_t here);
    port_mask_t mask;
    mask             = '0;
    mask[PORT_EAST]  = dest.x > here.x;
    mask[PORT_WEST]  = dest.x < here.x;
    mask[PORT_NORTH] = dest.y > here.y;
    mask[PORT_SOUTH] = dest.y < here.y;
    mask[PORT_UP]    = dest.z > here.z;
    mask[PORT_DOWN]  = dest.z < here.z;
    mask[PORT_LOCAL] = (dest == here);
    return mask;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Generic circular FIFO with occupancy count; refuses pushes when full even
// if a pop happens in the same cycle, and never bypasses input to output.
module flit_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; empty/count already mask stale
  // entries, and leaving it out keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/router_input_buffer.sv
// Per-direction router input stage: buffers link flits and attaches the
// minimal-path candidate port mask, computed once when the flit enqueues.
module router_input_buffer
  import noc_pkg::*;
#(
  parameter  int HEADER_WIDTH = 32,
  parameter  int DATA_WIDTH   = 32,
  parameter  int DEPTH        = 4,
  parameter  int COORD_WIDTH  = 4,
  localparam int FLIT_WIDTH   = HEADER_WIDTH + DATA_WIDTH,
  localparam int CNT_WIDTH    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COORD_WIDTH-1:0] local_x,
  input  logic [COORD_WIDTH-1:0] local_y,
  input  logic [COORD_WIDTH-1:0] local_z,
  input  logic [FLIT_WIDTH-1:0]  din,
  input  logic                   din_valid,
  output logic                   ready,
  output logic [FLIT_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  output logic [NUM_PORTS-1:0]   dout_route,
  input  logic                   dout_ready,
  output logic [CNT_WIDTH-1:0]   count
);

  localparam int WORD_WIDTH = FLIT_WIDTH + NUM_PORTS;

  mesh_pos_t                 dest_pos;
  mesh_pos_t                 here_pos;
  port_mask_t                din_route;
  logic                      rst_done;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [WORD_WIDTH-1:0]     head_word;

  // The header occupies the top HEADER_WIDTH bits, so its LSB sits at DATA_WIDTH.
  assign dest_pos.x = MAX_COORD_WIDTH'(din[DATA_WIDTH                 +: COORD_WIDTH]);
  assign dest_pos.y = MAX_COORD_WIDTH'(din[DATA_WIDTH + COORD_WIDTH   +: COORD_WIDTH]);
  assign dest_pos.z = MAX_COORD_WIDTH'(din[DATA_WIDTH + 2*COORD_WIDTH +: COORD_WIDTH]);
  assign here_pos.x = MAX_COORD_WIDTH'(local_x);
  assign here_pos.y = MAX_COORD_WIDTH'(local_y);
  assign here_pos.z = MAX_COORD_WIDTH'(local_z);
  assign din_route  = compute_route(dest_pos, here_pos);

  // Holds ready low through reset and releases it one edge after reset lifts.
  always_ff @(posedge clk) begin
    if (!reset) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  assign ready = rst_done && !fifo_full;

  flit_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (din_valid && ready),
    .push_data ({din, din_route}),
    .pop       (dout_valid && dout_ready),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign dout_valid = !fifo_empty;
  assign dout       = head_word[WORD_WIDTH-1 -: FLIT_WIDTH];
  assign dout_route = head_word[NUM_PORTS-1:0];

endmodule

// File: tb/tb_router_input_buffer.sv
// Self-checking bench for router_input_buffer: directed route table, corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_router_input_buffer;

  localparam int DEPTH = 4;
  localparam int LX = 2, LY = 2, LZ = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  local_x, local_y, local_z;
  logic [63:0] din;
  logic        din_valid;
  logic        ready;
  logic [63:0] dout;
  logic        dout_valid;
  logic [6:0]  dout_route;
  logic        dout_ready;
  logic [2:0]  count;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [63:0] flit;
    logic [6:0]  route;
  } entry_t;

  entry_t q[$];
  bit     m_rdy = 1'b0;

  typedef struct {
    int         dx, dy, dz;
    logic [6:0] exp_route;
  } vec_t;

  vec_t vecs[6];

  router_input_buffer #(
    .HEADER_WIDTH (32),
    .DATA_WIDTH   (32),
    .DEPTH        (DEPTH),
    .COORD_WIDTH  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .local_x    (local_x),
    .local_y    (local_y),
    .local_z    (local_z),
    .din        (din),
    .din_valid  (din_valid),
    .ready      (ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_route (dout_route),
    .dout_ready (dout_ready),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] mk_flit(input int dx, input int dy, input int dz,
                                          input logic [31:0] payload);
    logic [31:0] hdr;
    hdr        = '0;
    hdr[3:0]   = dx[3:0];
    hdr[7:4]   = dy[3:0];
    hdr[11:8]  = dz[3:0];
    hdr[31:24] = 8'h5A;
    return {hdr, payload};
  endfunction

  // Route rule stated per axis; local is "no axis needs to move".
  function automatic logic [6:0] ref_route(input int dx, input int dy, input int dz);
    logic [6:0] r;
    r = '0;
    if (dx < LX) r[0] = 1'b1;
    if (dy > LY) r[1] = 1'b1;
    if (dx > LX) r[2] = 1'b1;
    if (dy < LY) r[3] = 1'b1;
    if (dz > LZ) r[4] = 1'b1;
    if (dz < LZ) r[5] = 1'b1;
    if (r[5:0] == 6'd0) r[6] = 1'b1;
    return r;
  endfunction

  // Drive one cycle of inputs, clock it, then advance the reference model.
  task automatic cycle(input logic rst, input logic dv, input int dx, input int dy,
                       input int dz, input logic [31:0] payload, input logic dr);
    bit          acc, pp;
    logic [63:0] f;
    f          = mk_flit(dx, dy, dz, payload);
    reset      = rst;
    din_valid  = dv;
    din        = f;
    dout_ready = dr;
    acc = rst && dv && m_rdy && (q.size() < DEPTH);
    pp  = rst && dr && (q.size() > 0);
    @(posedge clk);
    #1;
    if (!rst) begin
      q.delete();
      m_rdy = 1'b0;
    end else begin
      if (pp) q.delete(0);
      if (acc) q.push_back('{f, ref_route(dx, dy, dz)});
      m_rdy = 1'b1;
    end
  endtask

  task automatic check_model();
    check("m_ready", ready, m_rdy && (q.size() < DEPTH));
    check("m_valid", dout_valid, q.size() > 0);
    check("m_count", count, q.size());
    if (q.size() > 0) begin
      check("m_dout", dout, q[0].flit);
      check("m_route", dout_route, q[0].route);
    end
  endtask

  initial begin
    vecs[0] = '{3, 1, 2, 7'b0001100};
    vecs[1] = '{2, 2, 2, 7'b1000000};
    vecs[2] = '{0, 2, 5, 7'b0010001};
    vecs[3] = '{15, 15, 15, 7'b0010110};
    vecs[4] = '{0, 0, 0, 7'b0101001};
    vecs[5] = '{2, 3, 1, 7'b0100010};

    local_x = 4'(LX); local_y = 4'(LY); local_z = 4'(LZ);
    reset = 1'b0; din_valid = 1'b0; din = '0; dout_ready = 1'b0;

    // Reset held with din_valid asserted.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1, 1, 1, 32'hDEAD, 1'b0);
      check("rst_ready", ready, 0);
      check("rst_valid", dout_valid, 0);
      check("rst_count", count, 0);
    end
    cycle(1'b1, 1'b0, 0, 0, 0, 32'h0, 1'b0);
    check("rel_ready", ready, 1);
    check("rel_count", count, 0);

    // Route table: push one flit into an empty FIFO, inspect, pop.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, vecs[i].dx, vecs[i].dy, vecs[i].dz, 32'h100 + i, 1'b0);
      check("rt_valid", dout_valid, 1);
      check("rt_route", dout_route, vecs[i].exp_route);
      check("rt_dout", dout, mk_flit(vecs[i].dx, vecs[i].dy, vecs[i].dz, 32'h100 + i));
      cycle(1'b1, 1'b0, 0, 0, 0, 32'h0, 1'b1);
      check("rt_count", count, 0);
    end

    // Fill: five back-to-back offers, only four accepted.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 2, 2, 2, 32'hA + i, 1'b0);
      check("fill_count", count, (i < 4) ? i + 1 : 4);
    end
    check("fill_ready", ready, 0);
    for (int i = 0; i < 4; i++) begin
      check("drain_dout", dout[31:0], 32'hA + i);
      cycle(1'b1, 1'b0, 0, 0, 0, 32'h0, 1'b1);
    end
    check("drain_valid", dout_valid, 0);
    check("drain_count", count, 0);

    // Concurrent push/pop at count 2; pointers wrap several times.
    cycle(1'b1, 1'b1, 1, 2, 3, 32'h200, 1'b0);
    cycle(1'b1, 1'b1, 1, 2, 3, 32'h201, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b1, 1, 2, 3, 32'h202 + k, 1'b1);
      check("cc_count", count, 2);
      check("cc_head", dout[31:0], 32'h201 + k);
    end
    for (int k = 0; k < 2; k++) begin
      check("cc_tail", dout[31:0], 32'h20A + k);
      cycle(1'b1, 1'b0, 0, 0, 0, 32'h0, 1'b1);
    end
    check("cc_empty", dout_valid, 0);

    // Full plus simultaneous pop: push refused.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 4, 4, 4, 32'h300 + i, 1'b0);
    check("fp_ready0", ready, 0);
    cycle(1'b1, 1'b1, 4, 4, 4, 32'h3FF, 1'b1);
    check("fp_count", count, 3);
    check("fp_ready1", ready, 1);
    for (int i = 1; i < 4; i++) begin
      check("fp_order", dout[31:0], 32'h300 + i);
      cycle(1'b1, 1'b0, 0, 0, 0, 32'h0, 1'b1);
    end
    check("fp_empty", dout_valid, 0);

    // Mid-stream reset discards stored flits.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 5, 5, 5, 32'h400 + i, 1'b0);
    check("mr_count3", count, 3);
    cycle(1'b0, 1'b0, 0, 0, 0, 32'h0, 1'b0);
    check("mr_count0", count, 0);
    check("mr_valid0", dout_valid, 0);
    check("mr_ready0", ready, 0);
    cycle(1'b1, 1'b0, 0, 0, 0, 32'h0, 1'b0);
    check("mr_ready1", ready, 1);
    cycle(1'b1, 1'b1, 0, 2, 5, 32'h4AA, 1'b0);
    check("mr_valid1", dout_valid, 1);
    check("mr_route", dout_route, 7'b0010001);
    check("mr_dout", dout, mk_flit(0, 2, 5, 32'h4AA));
    cycle(1'b1, 1'b0, 0, 0, 0, 32'h0, 1'b1);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      int dx, dy, dz;
      if ($urandom_range(0, 3) == 0) begin
        dx = LX; dy = LY; dz = LZ;
      end else begin
        dx = $urandom_range(0, 15);
        dy = $urandom_range(0, 15);
        dz = $urandom_range(0, 15);
      end
      cycle($urandom_range(0, 59) != 0, $urandom_range(0, 9) < 7,
            dx, dy, dz, $urandom, $urandom_range(0, 1) == 1);
      check_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/router_input_buffer.md
Name: router_input_buffer

Overview:
- Per-port input stage placed directly upstream of `router`; one instance per input direction (west, north, east, south, up, down, local).
- Accepts flits from the link with a valid/ready handshake and stores them in a circular FIFO.
- Computes a minimal-path candidate output mask from the flit's header destination, once, at enqueue.
- Presents the flit and its stored mask to the router's switch allocator, which pops it.

Parameters:
- HEADER_WIDTH, 32, header bits of a flit.
- DATA_WIDTH, 32, payload bits of a flit.
- FLIT_WIDTH, HEADER_WIDTH+DATA_WIDTH, derived; not overridden.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- COORD_WIDTH, 4, bits per mesh coordinate; 3*COORD_WIDTH <= HEADER_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- local_x  input  COORD_WIDTH  this router's X coordinate; static.
- local_y  input  COORD_WIDTH  this router's Y coordinate; static.
- local_z  input  COORD_WIDTH  this router's Z coordinate; static.
- din  input  FLIT_WIDTH  incoming flit.
- din_valid  input  1  din holds a valid flit.
- ready  output  1  buffer can accept a flit this cycle.
- dout  output  FLIT_WIDTH  head-of-FIFO flit.
- dout_valid  output  1  FIFO non-empty.
- dout_route  output  7  candidate output ports for the head flit.
- dout_ready  input  1  router pops the head flit.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset is sampled on clk while reset==0:
  - read/write pointers and count go to 0;
  - ready=0 during reset, then 1 from the first cycle after reset deasserts;
  - dout_valid=0; dout and dout_route are don't-care while dout_valid=0.
- Header location: header = din[FLIT_WIDTH-1 -: HEADER_WIDTH].
  - dest_x = header[COORD_WIDTH-1:0].
  - dest_y = header[2*COORD_WIDTH-1:COORD_WIDTH].
  - dest_z = header[3*COORD_WIDTH-1:2*COORD_WIDTH].
- Port index order (shared with router): 0 west, 1 north, 2 east, 3 south, 4 up, 5 down, 6 local.
- Route mask, computed combinationally from din, unsigned compares:
  - bit2 (east) = dest_x > local_x; bit0 (west) = dest_x < local_x;
  - bit1 (north) = dest_y > local_y; bit3 (south) = dest_y < local_y;
  - bit4 (up) = dest_z > local_z; bit5 (down) = dest_z < local_z;
  - bit6 (local) = all three coordinates equal;
  - exactly one of bit6 or bits[5:0] is non-zero. The router selects adaptively among set bits.
- Push: when din_valid && ready, store {din, mask} at wr_ptr; wr_ptr advances modulo DEPTH.
- Pop: when dout_valid && dout_ready, rd_ptr advances modulo DEPTH.
- ready = (count != DEPTH), from registered count only; no combinational path from dout_ready.
  - When full, a push is refused even if a pop happens in the same cycle.
- dout/dout_route read the storage at rd_ptr combinationally. dout_valid = (count != 0).
- Latency: a flit pushed in cycle N appears on dout in cycle N+1 if the FIFO was empty. No bypass.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Push with count==0 and dout_ready=1: no pop that cycle (dout_valid=0), so count becomes 1.
- din_valid while ready=0: flit ignored. The upstream sender holds it.
- Pointer wrap: DEPTH is a power of two, so pointers wrap naturally.
- Reset asserted mid-operation discards all stored flits. No partial drain.

Decomposition:
- Package `noc_pkg`:
  - port-index constants (PORT_WEST..PORT_LOCAL, NUM_PORTS=7);
  - typedef `port_mask_t` (logic [6:0]);
  - function `compute_route(dest, local)` returning port_mask_t.
- One sub-module `flit_fifo` (generic storage, pointers, count, full/empty), parameterised by width; instantiated with width FLIT_WIDTH+7.
- Route logic stays in the top level via the package function.

Test Plan:
- Reset: hold reset=0 for 3 cycles with din_valid=1 -> ready=0, dout_valid=0, count=0; one cycle after release, ready=1.
- Route: local=(2,2,2), push dest (3,1,2) -> dout_route=7'b0001100 (east, south); push dest (2,2,2) -> 7'b1000000; push dest (0,2,5) -> 7'b0010001 (west, up).
- Fill (DEPTH=4, dout_ready=0): push 5 flits 0xA..0xE back-to-back -> first 4 accepted, count=4, ready=0, 0xE held by sender; then pop -> outputs in order 0xA,0xB,0xC,0xD.
- Concurrent push/pop at count=2 for 10 cycles -> count stays 2, FIFO order preserved, pointers wrap with no loss.
- Full plus simultaneous pop: count=4, din_valid=1, dout_ready=1 -> push refused, count=3 next cycle, ready=1.
- Mid-stream reset: count=3, assert reset one cycle -> count=0, dout_valid=0; next push appears on dout one cycle later with the correct route.
